// File: rtl/sr_flag_ctrl_pkg.sv
// Shared op codes, FSM encoding and the expected-readback helper for the SR flag controller.
package sr_ctrl_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TGL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  // Value the flop must show after the op, given Q as seen before the drive lands.
  function automatic logic op_expect(input logic [1:0] op, input logic q_now);
    case (op)
      OP_CLR:  op_expect = 1'b0;
      OP_SET:  op_expect = 1'b1;
      OP_TGL:  op_expect = ~q_now;
      default: op_expect = q_now;
    endcase
  endfunction

endpackage

// File: rtl/sr_flag_ctrl_if.sv
// Two-requester command bus plus the completion report of the SR flag controller.
interface sr_flag_ctrl_if #(
  parameter int IDX_W = 3
);
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0][IDX_W-1:0] req_idx;
  logic [1:0][1:0]       req_op;
  logic                  done;
  logic                  done_id;
  logic                  err;

  modport master (
    output req_valid, req_idx, req_op,
    input  req_ready, done, done_id, err
  );

  modport slave (
    input  req_valid, req_idx, req_op,
    output req_ready, done, done_id, err
  );
endinterface

// File: rtl/sr_flag_ctrl_arb.sv
// Two-way round-robin arbiter: combinational grant, last winner remembered on advance.
module rr_arb2 (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last <= 1'b1;
    end else if (advance) begin
      last <= grant[1];
    end
  end

endmodule

// File: rtl/sr_flag_ctrl.sv
// Shares a bank of clocked SR flops between two requesters: one-cycle S/R pulse, then Q readback check.
// Accept -> DRIVE -> CHECK (done) -> IDLE; ready only in IDLE, so one command per three cycles.
module sr_flag_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int N_FLAGS = 8,
  parameter int IDX_W   = $clog2(N_FLAGS)
) (
  input  logic               CLK,
  input  logic               RST_N,
  sr_flag_ctrl_if.slave      req,
  output logic [N_FLAGS-1:0] S,
  output logic [N_FLAGS-1:0] R,
  input  logic [N_FLAGS-1:0] Q
);

  localparam int NP = 1 << IDX_W;

  state_t           state;
  logic [IDX_W-1:0] cmd_idx;
  logic [1:0]       cmd_op;
  logic             cmd_id;
  logic             cmd_ok;
  logic             exp_q;
  logic             done_q;
  logic             done_id_q;

  logic [1:0]       grant;
  logic [1:0]       ready;
  logic             xfer;
  logic             gid;
  logic [IDX_W-1:0] sel_idx;
  logic [1:0]       sel_op;
  logic             sel_ok;
  logic [NP-1:0]    q_pad;
  logic [NP-1:0]    sel_hot;
  logic [N_FLAGS-1:0] sel_vec;

  rr_arb2 u_arb (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .valid   (req.req_valid),
    .advance (xfer),
    .grant   (grant)
  );

  // RST_N gates ready so nothing can be accepted while the block is held in reset.
  assign ready         = {2{RST_N && (state == ST_IDLE)}} & grant;
  assign req.req_ready = ready;
  assign xfer          = |(req.req_valid & ready);
  assign gid           = grant[1];
  assign sel_idx       = req.req_idx[gid];
  assign sel_op        = req.req_op[gid];

  // Q padded to a power of two so an out-of-range index reads a harmless zero.
  assign q_pad   = NP'(Q);
  assign sel_ok  = ({1'b0, sel_idx} < (IDX_W + 1)'(N_FLAGS));
  assign sel_hot = NP'(1) << sel_idx;
  assign sel_vec = sel_ok ? sel_hot[N_FLAGS-1:0] : '0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      S         <= '0;
      R         <= '0;
      cmd_idx   <= '0;
      cmd_op    <= OP_HOLD;
      cmd_id    <= 1'b0;
      cmd_ok    <= 1'b0;
      exp_q     <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (xfer) begin
            state   <= ST_DRIVE;
            cmd_idx <= sel_idx;
            cmd_op  <= sel_op;
            cmd_id  <= gid;
            cmd_ok  <= sel_ok;
            case (sel_op)
              OP_SET:  S <= sel_vec;
              OP_CLR:  R <= sel_vec;
              OP_TGL: begin
                if (q_pad[sel_idx]) R <= sel_vec;
                else                S <= sel_vec;
              end
              default: ;
            endcase
          end
        end
        ST_DRIVE: begin
          // Q has not moved yet, so this is the pre-drive value TOGGLE and HOLD compare against.
          S         <= '0;
          R         <= '0;
          exp_q     <= op_expect(cmd_op, q_pad[cmd_idx]);
          done_q    <= 1'b1;
          done_id_q <= cmd_id;
          state     <= ST_CHECK;
        end
        ST_CHECK: begin
          done_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // err looks at Q in the CHECK cycle itself, after the flop has taken the drive.
  assign req.done    = done_q;
  assign req.done_id = done_id_q;
  assign req.err     = done_q & (~cmd_ok | (q_pad[cmd_idx] != exp_q));

endmodule

// File: doc/sr_flag_ctrl.md
# sr_flag_ctrl

Controller that owns a bank of external clocked SR flip-flops (the lab `sr` cell, one per flag) and shares it between two requesters. Each requester posts SET / CLEAR / TOGGLE / HOLD commands on a flag index. The block arbitrates round-robin and drives the selected flop's S or R for exactly one cycle. It then reads back Q to confirm the result. S=R=1 is never presented to any flop.

## Interface
Parameters:
- `N_FLAGS`, 8, number of SR flops in the bank (2..32).
- `IDX_W`, `$clog2(N_FLAGS)`, width of the flag index.

Ports:
- `CLK` in 1: single clock; also clocks the SR bank.
- `RST_N` in 1: asynchronous, active-low reset.
- `req_valid` in 2: per-requester command valid.
- `req_ready` out 2: per-requester accept; a command transfers when valid and ready are both high on a CLK rising edge.
- `req_idx` in 2×IDX_W: flag index per requester.
- `req_op` in 2×2: op code per requester.
- `S` out N_FLAGS: set drives to the bank.
- `R` out N_FLAGS: reset drives to the bank.
- `Q` in N_FLAGS: bank outputs, readback only.
- `done` out 1: one-cycle completion pulse.
- `done_id` out 1: requester that owns the completing command.
- `err` out 1: valid with `done`; readback mismatch or bad index.

## Operation
- Op codes:
  - 00 HOLD: no drive; expected = Q[idx].
  - 01 CLEAR: R[idx]; expected 0.
  - 10 SET: S[idx]; expected 1.
  - 11 TOGGLE: S if Q[idx]=0, else R; expected = ~Q[idx], sampled in DRIVE.
- FSM states: IDLE, DRIVE, CHECK.
  - IDLE → DRIVE when a transfer occurs; the command is latched into cmd_idx, cmd_op and cmd_id.
  - DRIVE → CHECK unconditionally. At most one bit of S|R is high, for this cycle only.
  - CHECK → IDLE unconditionally. `done`=1, `done_id`=cmd_id, and `err`=(Q[cmd_idx]≠expected) or bad index.
- Arbitration: `req_ready[i]` = (state==IDLE) & grant[i]. The grant is combinational from `req_valid` and the `last` register.
  - One valid requester → that requester is granted.
  - Both valid → the requester ≠ `last` is granted.
  - `last` updates on each transfer and resets to 1, so requester 0 wins the first tie.
- Bad index (`idx` ≥ N_FLAGS): the command is accepted but drives nothing. CHECK reports `err`=1 with Q ignored.
- Invariant: (S & R) == 0 and popcount(S|R) ≤ 1 in every cycle, including reset.
- Requesters may change `req_idx`/`req_op` freely while not ready. Values are held internally after acceptance.

## Timing
- Reset values: S=0, R=0, `done`=0, `done_id`=0, `err`=0, `req_ready`=0, state IDLE, `last`=1.
- Accept edge t0 → DRIVE in cycle t0+1 → the flop updates Q at the t0+2 edge → CHECK/`done` in cycle t0+2 → IDLE in t0+3.
- Latency from accept to `done` is 2 cycles. Throughput is one command per 3 cycles, and ready is low in DRIVE and CHECK.
- No back-to-back accept: the earliest next accept is at the edge ending the CHECK cycle+1, i.e. while in IDLE.
- RST_N asserted mid-command: all outputs go to 0 immediately (async) and the command is dropped with no `done`. Flop contents are not touched by this block.
- RST_N deassertion takes effect at the next CLK edge; the first accept is possible at that edge if valid.

## Structure
- Package `sr_ctrl_pkg`:
  - op code localparams `OP_HOLD`, `OP_CLR`, `OP_SET`, `OP_TGL`
  - state encoding `ST_IDLE`, `ST_DRIVE`, `ST_CHECK`
- Sub-module `rr_arb2`:
  - 2-requester round-robin grant with a `last` register
  - inputs: CLK, RST_N, valid[1:0], advance
  - output: grant[1:0]
- The top level holds the FSM, the command register, the S/R decode and the readback compare.

## Test plan
- Reset then single SET: req0 idx=3 op=10. Expect:
  - S=0000_1000 for one cycle
  - `done`=1 two cycles after accept, `done_id`=0, `err`=0
  - Q[3]=1
- TOGGLE twice: req1 idx=5 op=11, twice. Expect:
  - first command: S[5] pulse, then Q[5]=1
  - second command: R[5] pulse, then Q[5]=0
  - both `err`=0
- Contention: both valid continuously from reset; req0 SET idx=0, req1 CLEAR idx=0. Expect:
  - grants alternate 0,1,0,1
  - `done_id` sequence 0,1,0,1
  - S and R never both high
- Readback fault: force Q[2] stuck at 0, then SET idx=2. Expect `done`=1 with `err`=1.
- Bad index with N_FLAGS=6: op=10 idx=7. Expect:
  - no S/R bit asserted
  - `err`=1 at `done`
- Reset mid-command: assert RST_N low during DRIVE. Expect:
  - S=R=0 immediately
  - no `done`
  - after release, a pending req0 is accepted on the first edge
